mem_arbiter: RTL

- Shares one single-port unified memory between the instruction-fetch port and the load/store data port of the RV32I core.
- Arbitrates between the two, sequences each memory transaction with a request/acknowledge handshake, and bounds it with a timeout.
- Generates the core-wide stall signal consumed by the control decoder and pipeline registers.

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_timeout_cnt.sv | 44 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Imported by the arbiter top and its counters.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_D  = 2'd2
    } arb_state_e;

    typedef enum logic {
        SEL_IF = 1'b0,
        SEL_D  = 1'b1
    } arb_sel_e;

    localparam int ARB_TIMEOUT_DEF    = 16;
    localparam int ARB_STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Loadable saturating up-counter with clear, enable and terminal count.
// Used for both the busy timeout and the fetch starvation count.
module arb_timeout_cnt #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load beats clear beats a saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-port memory,
// with per-transaction timeout and a fetch anti-starvation override.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = ARB_TIMEOUT_DEF,
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              bus_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int SV_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    arb_sel_e sel_d;
    logic     busy;
    logic     grant;
    logic     to_tc;
    logic     starve_full;
    logic     done;

    // Winner selection; a full starvation count hands the slot to fetch
    always_comb begin
        sel_d = SEL_IF;
        if (d_req && !(if_req && starve_full)) begin
            sel_d = SEL_D;
        end
    end

    assign busy  = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_D);
    assign grant = (state_q == ARB_IDLE) && (if_req || d_req);
    assign done  = busy && (mem_ack || to_tc);

    // Busy-cycle count: loaded to 1 on grant so it equals the busy cycle number
    arb_timeout_cnt #(
        .MAX (TIMEOUT),
        .W   (TO_W)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (done),
        .load_i     (grant),
        .load_val_i (TO_W'(1)),
        .en_i       (busy && !mem_ack),
        .tc_o       (to_tc)
    );

    // Data grants won while fetch was waiting
    arb_timeout_cnt #(
        .MAX (STARVE_MAX),
        .W   (SV_W)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (grant && (sel_d == SEL_IF)),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (grant && (sel_d == SEL_D) && if_req),
        .tc_o       (starve_full)
    );

    // Arbiter FSM; latches the winner's request for the whole busy phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant) begin
                        req_q <= 1'b1;
                        if (sel_d == SEL_D) begin
                            state_q <= ARB_BUSY_D;
                            we_q    <= d_we;
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                        end else begin
                            state_q <= ARB_BUSY_IF;
                            we_q    <= 1'b0;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                        end
                    end
                end
                ARB_BUSY_IF, ARB_BUSY_D: begin
                    if (done) begin
                        state_q <= ARB_IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Acks fire on memory completion or timeout; data only on real completion
    always_comb begin
        if_ack   = (state_q == ARB_BUSY_IF) && (mem_ack || to_tc);
        d_ack    = (state_q == ARB_BUSY_D) && (mem_ack || to_tc);
        if_rdata = '0;
        d_rdata  = '0;
        if ((state_q == ARB_BUSY_IF) && mem_ack) begin
            if_rdata = mem_rdata;
        end
        if ((state_q == ARB_BUSY_D) && mem_ack) begin
            d_rdata = mem_rdata;
        end
    end

    assign bus_err = busy && !mem_ack && to_tc;
    assign stall   = (if_req && !if_ack) || (d_req && !d_ack);

endmodule
